// File: rtl/branch_resolve_unit_if.sv
// Bundle-in / resolve-out bus for the branch resolve stage.
// master = operand-read side driving bundles, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int XLEN      = 32,
    parameter int NUM_SLOTS = 2,
    parameter int IMM_W     = 22
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                       in_valid;
    logic                       in_ready;
    logic                       stall;
    logic                       flush;
    logic [XLEN-1:0]            pc;
    logic [NUM_SLOTS-1:0]       slot_is_nop;
    logic [NUM_SLOTS-1:0]       slot_is_jmp;
    logic [NUM_SLOTS-1:0]       slot_is_imm;
    logic [NUM_SLOTS-1:0]       slot_zero_ext;
    logic [2*NUM_SLOTS-1:0]     slot_op;
    logic [XLEN*NUM_SLOTS-1:0]  slot_rs1;
    logic [XLEN*NUM_SLOTS-1:0]  slot_rs2;
    logic [IMM_W*NUM_SLOTS-1:0] slot_imm;
    logic                       out_valid;
    logic                       redirect;
    logic [XLEN-1:0]            redirect_pc;
    logic [SLOT_W-1:0]          redirect_slot;
    logic [NUM_SLOTS-1:0]       link_wr_en;
    logic [XLEN*NUM_SLOTS-1:0]  link_data;
    logic                       squashing;

    modport master (
        output in_valid, stall, flush, pc, slot_is_nop, slot_is_jmp, slot_is_imm,
               slot_zero_ext, slot_op, slot_rs1, slot_rs2, slot_imm,
        input  in_ready, out_valid, redirect, redirect_pc, redirect_slot,
               link_wr_en, link_data, squashing
    );

    modport slave (
        input  in_valid, stall, flush, pc, slot_is_nop, slot_is_jmp, slot_is_imm,
               slot_zero_ext, slot_op, slot_rs1, slot_rs2, slot_imm,
        output in_ready, out_valid, redirect, redirect_pc, redirect_slot,
               link_wr_en, link_data, squashing
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: evaluates all branch/jump slots of a VLIW bundle,
// registers the oldest taken redirect plus link writes, and squashes a fixed
// number of wrong-path bundles after each redirect.
module branch_resolve_unit #(
    parameter int XLEN          = 32,
    parameter int NUM_SLOTS     = 2,
    parameter int IMM_W         = 22,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bif
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;

    logic                           ev_found;
    logic [SW-1:0]                  ev_slot;
    logic [XLEN-1:0]                ev_pc;
    logic [NUM_SLOTS-1:0]           ev_link;
    logic [NUM_SLOTS-1:0][XLEN-1:0] ev_ldata;

    logic                           out_valid_q, out_valid_d;
    logic                           redirect_q, redirect_d;
    logic [XLEN-1:0]                redirect_pc_q, redirect_pc_d;
    logic [SW-1:0]                  redirect_slot_q, redirect_slot_d;
    logic [NUM_SLOTS-1:0]           link_wr_en_q, link_wr_en_d;
    logic [NUM_SLOTS-1:0][XLEN-1:0] link_data_q, link_data_d;
    logic [CW-1:0]                  cnt_q, cnt_d;

    // Evaluate every slot in parallel and keep the oldest taken one
    always_comb begin
        logic [XLEN-1:0]  rs1, rs2, imm_s, spc, tgt;
        logic [IMM_W-1:0] imm;
        logic             lt, cond, taken;
        rs1 = '0; rs2 = '0; imm_s = '0; spc = '0; tgt = '0; imm = '0;
        lt = 1'b0; cond = 1'b0; taken = 1'b0;
        ev_found = 1'b0;
        ev_slot  = '0;
        ev_pc    = '0;
        ev_link  = '0;
        ev_ldata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rs1 = bif.slot_rs1[i*XLEN +: XLEN];
            rs2 = bif.slot_rs2[i*XLEN +: XLEN];
            imm = bif.slot_imm[i*IMM_W +: IMM_W];
            spc = bif.pc + XLEN'(4 * i);
            lt  = bif.slot_zero_ext[i] ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
            unique case (bif.slot_op[i*2 +: 2])
                2'd0:    cond = (rs1 == rs2);
                2'd1:    cond = (rs1 != rs2);
                2'd2:    cond = lt;
                default: cond = !lt;
            endcase
            // JAL carries the full-width offset; everything else uses imm[11:0]
            imm_s = (bif.slot_is_jmp[i] && !bif.slot_is_imm[i]) ? XLEN'($signed(imm))
                                                                : XLEN'($signed(imm[11:0]));
            tgt   = (bif.slot_is_jmp[i] && bif.slot_is_imm[i])
                    ? ((rs1 + imm_s) & {{(XLEN-1){1'b1}}, 1'b0})
                    : (spc + imm_s);
            taken = !bif.slot_is_nop[i] && (bif.slot_is_jmp[i] || cond);
            ev_ldata[i] = spc + XLEN'(4);
            // A jump links unless an older slot already redirected
            ev_link[i]  = !bif.slot_is_nop[i] && bif.slot_is_jmp[i] && !ev_found;
            if (taken && !ev_found) begin
                ev_found = 1'b1;
                ev_slot  = SW'(i);
                ev_pc    = tgt;
            end
        end
    end

    // Next-state for the result registers and the squash shadow counter
    always_comb begin
        out_valid_d     = out_valid_q;
        redirect_d      = redirect_q;
        redirect_pc_d   = redirect_pc_q;
        redirect_slot_d = redirect_slot_q;
        link_wr_en_d    = link_wr_en_q;
        link_data_d     = link_data_q;
        cnt_d           = cnt_q;
        if (!bif.stall) begin
            out_valid_d = bif.in_valid && !bif.flush && (cnt_q == '0);
            if (out_valid_d) begin
                redirect_d      = ev_found;
                redirect_pc_d   = ev_pc;
                redirect_slot_d = ev_slot;
                link_wr_en_d    = ev_link;
                link_data_d     = ev_ldata;
            end else begin
                redirect_d   = 1'b0;
                link_wr_en_d = '0;
            end
            // Flush wins over arming the shadow for a presented redirect
            if (bif.flush)
                cnt_d = '0;
            else if (redirect_q)
                cnt_d = CW'(SHADOW_CYCLES);
            else if (cnt_q != '0)
                cnt_d = cnt_q - CW'(1);
        end
    end

    // Stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            redirect_slot_q <= '0;
            link_wr_en_q    <= '0;
            link_data_q     <= '0;
            cnt_q           <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            redirect_slot_q <= redirect_slot_d;
            link_wr_en_q    <= link_wr_en_d;
            link_data_q     <= link_data_d;
            cnt_q           <= cnt_d;
        end
    end

    assign bif.in_ready      = !bif.stall;
    assign bif.out_valid     = out_valid_q;
    assign bif.redirect      = redirect_q;
    assign bif.redirect_pc   = redirect_pc_q;
    assign bif.redirect_slot = redirect_slot_q;
    assign bif.link_wr_en    = link_wr_en_q;
    assign bif.link_data     = link_data_q;
    assign bif.squashing     = (cnt_q != '0);
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random bundles
// compared against a cycle-level reference model of the stage.
module tb_branch_resolve_unit;
    localparam int XL     = 32;
    localparam int NS     = 2;
    localparam int IW     = 22;
    localparam int SHADOW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XL), .NUM_SLOTS(NS), .IMM_W(IW)) bif();

    branch_resolve_unit #(.XLEN(XL), .NUM_SLOTS(NS), .IMM_W(IW), .SHADOW_CYCLES(SHADOW)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // stimulus fields
    bit          t_valid, t_stall, t_flush;
    logic [31:0] t_pc;
    bit          t_nop[NS], t_jmp[NS], t_isimm[NS], t_zext[NS];
    logic [1:0]  t_op[NS];
    logic [31:0] t_rs1[NS], t_rs2[NS];
    logic [21:0] t_imm[NS];

    // model state
    bit          m_ov, m_rd;
    logic [31:0] m_rpc;
    int          m_rslot;
    logic [NS-1:0] m_link;
    logic [31:0] m_ldata[NS];
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_rd = 0; m_rpc = 0; m_rslot = 0; m_link = 0; m_cnt = 0;
        for (int i = 0; i < NS; i++) m_ldata[i] = 0;
    endtask

    // Resolve one bundle from the ISA rules using wide integer arithmetic
    task automatic ref_eval(output bit found, output int idx, output logic [31:0] tpc,
                            output logic [NS-1:0] link);
        found = 0; idx = 0; tpc = 0; link = 0;
        for (int i = 0; i < NS; i++) begin
            longint a, b, imm;
            logic [31:0] spc, tg;
            bit tk;
            spc = t_pc + 32'(4 * i);
            if (t_nop[i]) continue;
            if (t_jmp[i] && !t_isimm[i]) begin
                imm = longint'(t_imm[i]) & 64'h3FFFFF;
                if (imm >= 64'd2097152) imm -= 64'd4194304;
            end else begin
                imm = longint'(t_imm[i]) & 64'hFFF;
                if (imm >= 64'd2048) imm -= 64'd4096;
            end
            if (t_jmp[i]) begin
                tk = 1;
                if (t_isimm[i]) tg = 32'((longint'(t_rs1[i]) + imm) & ~64'd1);
                else            tg = 32'(longint'(spc) + imm);
            end else begin
                a = t_zext[i] ? longint'(t_rs1[i]) : longint'(int'(t_rs1[i]));
                b = t_zext[i] ? longint'(t_rs2[i]) : longint'(int'(t_rs2[i]));
                case (t_op[i])
                    2'd0:    tk = (a == b);
                    2'd1:    tk = (a != b);
                    2'd2:    tk = (a < b);
                    default: tk = (a >= b);
                endcase
                tg = 32'(longint'(spc) + imm);
            end
            if (tk && !found) begin
                found = 1; idx = i; tpc = tg;
            end
        end
        if (found)
            for (int j = 0; j <= idx; j++) link[j] = t_jmp[j] && !t_nop[j];
    endtask

    // Advance the model by one clock edge using the current inputs
    task automatic model_next();
        bit f, nv;
        int idx;
        logic [31:0] tp;
        logic [NS-1:0] lk;
        if (t_stall) return;
        nv = t_valid && !t_flush && (m_cnt == 0);
        if (t_flush)          m_cnt = 0;
        else if (m_rd)        m_cnt = SHADOW;
        else if (m_cnt > 0)   m_cnt = m_cnt - 1;
        if (nv) begin
            ref_eval(f, idx, tp, lk);
            m_rd = f; m_rpc = tp; m_rslot = idx; m_link = lk;
            for (int i = 0; i < NS; i++) m_ldata[i] = t_pc + 32'(4 * i + 4);
        end else begin
            m_rd = 0; m_link = 0;
        end
        m_ov = nv;
    endtask

    task automatic drive();
        bif.in_valid = t_valid;
        bif.stall    = t_stall;
        bif.flush    = t_flush;
        bif.pc       = t_pc;
        for (int i = 0; i < NS; i++) begin
            bif.slot_is_nop[i]     = t_nop[i];
            bif.slot_is_jmp[i]     = t_jmp[i];
            bif.slot_is_imm[i]     = t_isimm[i];
            bif.slot_zero_ext[i]   = t_zext[i];
            bif.slot_op[i*2 +: 2]  = t_op[i];
            bif.slot_rs1[i*32 +: 32] = t_rs1[i];
            bif.slot_rs2[i*32 +: 32] = t_rs2[i];
            bif.slot_imm[i*IW +: IW] = t_imm[i];
        end
    endtask

    task automatic check_outs();
        chk("out_valid", 64'(bif.out_valid), 64'(m_ov));
        chk("redirect", 64'(bif.redirect), 64'(m_rd));
        chk("squashing", 64'(bif.squashing), 64'(m_cnt != 0));
        chk("link_wr_en", 64'(bif.link_wr_en), 64'(m_link));
        for (int i = 0; i < NS; i++) chk("link_data", 64'(bif.link_data[i*32 +: 32]), 64'(m_ldata[i]));
        if (m_rd) begin
            chk("redirect_pc", 64'(bif.redirect_pc), 64'(m_rpc));
            chk("redirect_slot", 64'(bif.redirect_slot), 64'(m_rslot));
        end
    endtask

    // One clock: drive, check in_ready, step model, sample after the edge
    task automatic cyc();
        drive();
        #1;
        chk("in_ready", 64'(bif.in_ready), 64'(!t_stall));
        model_next();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic clr_slots();
        t_flush = 0; t_stall = 0;
        for (int i = 0; i < NS; i++) begin
            t_nop[i] = 1; t_jmp[i] = 0; t_isimm[i] = 0; t_zext[i] = 0;
            t_op[i] = 0; t_rs1[i] = 0; t_rs2[i] = 0; t_imm[i] = 0;
        end
    endtask

    task automatic idle(input int n);
        t_valid = 0; t_stall = 0; t_flush = 0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    // slot0 BEQ 5==5 at pc 0x100 -> taken to 0x110
    task automatic taken_bundle();
        clr_slots();
        t_valid = 1; t_pc = 32'h100;
        t_nop[0] = 0; t_op[0] = 2'd0; t_rs1[0] = 5; t_rs2[0] = 5; t_imm[0] = 22'h010;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 8));
            2: begin
                case ($urandom_range(0, 3))
                    0:       return 32'h7FFFFFFF;
                    1:       return 32'h80000000;
                    2:       return 32'hFFFFFFFF;
                    default: return 32'h00000000;
                endcase
            end
            default: return 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        t_valid = 0; t_pc = 0;
        clr_slots();
        drive();
        model_reset();
        #12 rst = 1'b0;
        #1;
        check_outs();

        // BEQ taken beats the younger JAL
        taken_bundle();
        t_nop[1] = 0; t_jmp[1] = 1; t_isimm[1] = 0; t_imm[1] = 22'h40;
        cyc();
        chk("t2_redirect", 64'(bif.redirect), 64'd1);
        chk("t2_pc", 64'(bif.redirect_pc), 64'h110);
        chk("t2_slot", 64'(bif.redirect_slot), 64'd0);
        chk("t2_link", 64'(bif.link_wr_en), 64'd0);
        idle(3);

        // BLTU not taken, JALR taken with link
        clr_slots();
        t_valid = 1; t_pc = 32'h100;
        t_nop[0] = 0; t_zext[0] = 1; t_op[0] = 2'd2; t_rs1[0] = 32'hFFFFFFFF; t_rs2[0] = 1;
        t_nop[1] = 0; t_jmp[1] = 1; t_isimm[1] = 1; t_rs1[1] = 32'h2003; t_imm[1] = 22'h004;
        cyc();
        chk("t3_pc", 64'(bif.redirect_pc), 64'h2006);
        chk("t3_slot", 64'(bif.redirect_slot), 64'd1);
        chk("t3_link", 64'(bif.link_wr_en), 64'b10);
        chk("t3_ldata1", 64'(bif.link_data[63:32]), 64'h108);
        idle(3);

        // signed BLT taken, BGE not
        clr_slots();
        t_valid = 1; t_pc = 32'h200;
        t_nop[0] = 0; t_op[0] = 2'd2; t_rs1[0] = 32'hFFFFFFFF; t_rs2[0] = 1; t_imm[0] = 22'h020;
        cyc();
        chk("t4_blt", 64'(bif.redirect), 64'd1);
        idle(3);
        t_valid = 1; t_op[0] = 2'd3;
        cyc();
        chk("t4_bge", 64'(bif.redirect), 64'd0);
        chk("t4_valid", 64'(bif.out_valid), 64'd1);

        // shadow drops two wrong-path bundles
        taken_bundle();
        cyc();
        t_valid = 0;
        cyc();
        clr_slots();
        t_valid = 1;
        cyc(); chk("t5_b1", 64'(bif.out_valid), 64'd0);
        cyc(); chk("t5_b2", 64'(bif.out_valid), 64'd0);
        cyc(); chk("t5_b3", 64'(bif.out_valid), 64'd1);

        // stall holds redirect and freezes the counter
        taken_bundle();
        cyc();
        t_stall = 1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_hold_rd", 64'(bif.redirect), 64'd1);
            chk("t6_hold_sq", 64'(bif.squashing), 64'd0);
        end
        t_stall = 0; t_valid = 0;
        cyc();
        chk("t6_armed", 64'(bif.squashing), 64'd1);
        idle(3);

        // flush on the redirect cycle kills the shadow
        taken_bundle();
        cyc();
        t_flush = 1;
        cyc();
        chk("t7_valid", 64'(bif.out_valid), 64'd0);
        chk("t7_sq", 64'(bif.squashing), 64'd0);
        t_flush = 0;
        idle(1);

        // async reset in the middle of a shadow
        taken_bundle();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("t1_valid", 64'(bif.out_valid), 64'd0);
        chk("t1_rd", 64'(bif.redirect), 64'd0);
        chk("t1_link", 64'(bif.link_wr_en), 64'd0);
        chk("t1_sq", 64'(bif.squashing), 64'd0);
        chk("t1_pc", 64'(bif.redirect_pc), 64'd0);
        #1 rst = 1'b0;
        model_reset();

        // random bundles
        for (int n = 0; n < 600; n++) begin
            t_valid = ($urandom_range(0, 9) < 8);
            t_stall = ($urandom_range(0, 9) == 0);
            t_flush = ($urandom_range(0, 19) == 0);
            t_pc    = $urandom & ~32'h3;
            for (int i = 0; i < NS; i++) begin
                t_nop[i]   = ($urandom_range(0, 4) == 0);
                t_jmp[i]   = ($urandom_range(0, 3) == 0);
                t_isimm[i] = 1'($urandom);
                t_zext[i]  = 1'($urandom);
                t_op[i]    = 2'($urandom);
                t_rs1[i]   = pick();
                t_rs2[i]   = ($urandom_range(0, 2) == 0) ? t_rs1[i] : pick();
                t_imm[i]   = 22'($urandom);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
